// File: rtl/hls_sobel_pkg.sv
// Shared constants and the saturation helper for the Sobel multiply pipeline.
package hls_sobel_pkg;

  localparam logic [1:0] MODE_UU = 2'd0;
  localparam logic [1:0] MODE_SU = 2'd1;
  localparam logic [1:0] MODE_US = 2'd2;
  localparam logic [1:0] MODE_SS = 2'd3;

  // Widest intermediate the clamp handles; product + rounding bit must fit.
  localparam int MAX_W = 64;

  // Clamp v to the signed/unsigned range of a w-bit result when sat is set.
  // With sat clear the value passes through and the caller keeps the low bits.
  function automatic logic [MAX_W-1:0] sat_clamp(
    input  logic signed [MAX_W-1:0] v,
    input  logic                    is_signed,
    input  logic                    sat,
    input  int unsigned             w,
    output logic                    ovf
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic [MAX_W-1:0]        res;
    if (is_signed) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = 64'sd0;
    end
    ovf = 1'b0;
    res = v;
    if (sat) begin
      if (v > hi) begin
        res = hi;
        ovf = 1'b1;
      end else if (v < lo) begin
        res = lo;
        ovf = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hls_sobel_pipe_stage.sv
// One pipeline slot: payload register plus valid bit. The slot empties when
// downstream can take it and refills whenever the upstream loads it.
module hls_sobel_pipe_stage
  import hls_sobel_pkg::*;
#(
  parameter int W        = 8,
  parameter bit RST_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         down_rdy_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] q_q;

  always_comb begin
    vld_d = vld_q;
    if (down_rdy_i) vld_d = 1'b0;
    if (load_i)     vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) vld_q <= 1'b0;
    else          vld_q <= vld_d;
  end

  if (RST_DATA) begin : g_rst
    always_ff @(posedge clk) begin
      if (!reset_n)    q_q <= '0;
      else if (load_i) q_q <= d_i;
    end
  end else begin : g_nrst
    always_ff @(posedge clk) begin
      if (load_i) q_q <= d_i;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = q_q;

endmodule

// File: rtl/hls_sobel_mul_pipe.sv
// Pipelined signed/unsigned multiplier with round, shift and saturation,
// valid/ready at both ends and bubble-collapsing stage advance.
module hls_sobel_mul_pipe
  import hls_sobel_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int B_W       = 14,
  parameter int OUT_W     = 22,
  parameter int NUM_STAGE = 4,
  parameter int SHIFT     = 0,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             busy
);

  localparam int PW     = A_W + B_W + 2;
  localparam int W1     = A_W + B_W + 3 + TAG_W;
  localparam int WM     = PW + 2 + TAG_W;
  localparam int WN     = OUT_W + 1 + TAG_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [PW:0] RND = (SHIFT > 0) ? ((PW+1)'(1) <<< RND_SH) : '0;

  logic [NUM_STAGE:1]   vld;
  logic [NUM_STAGE+1:1] rdy;
  logic [NUM_STAGE:1]   load;

  // A stage can take data if the consumer is ready or any slot at or after it
  // is empty; built from valid bits only so there is no combinational ring.
  assign rdy[NUM_STAGE+1] = out_ready;
  for (genvar i = 1; i <= NUM_STAGE; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&vld[NUM_STAGE:i]);
  end

  assign in_ready = rdy[1];
  assign load[1]  = in_valid & rdy[1];

  // Stage 1: operand capture
  logic [W1-1:0]    s1_q;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [1:0]       s1_mode;
  logic             s1_sat;
  logic [TAG_W-1:0] s1_tag;

  hls_sobel_pipe_stage #(.W(W1), .RST_DATA(1'b0)) u_s1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load[1]),
    .d_i        ({in_a, in_b, in_mode, in_sat, in_tag}),
    .down_rdy_i (rdy[2]),
    .vld_o      (vld[1]),
    .q_o        (s1_q)
  );

  assign {s1_a, s1_b, s1_mode, s1_sat, s1_tag} = s1_q;

  logic signed [A_W:0]  a_ext;
  logic signed [B_W:0]  b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = $signed({s1_mode[0] & s1_a[A_W-1], s1_a});
  assign b_ext = $signed({s1_mode[1] & s1_b[B_W-1], s1_b});
  assign prod  = PW'(a_ext) * PW'(b_ext);

  // Stage 2 holds the product; stages 3..NUM_STAGE-1 just retime it.
  logic [WM-1:0] mid_d [2:NUM_STAGE-1];
  logic [WM-1:0] mid_q [2:NUM_STAGE-1];

  assign mid_d[2] = {prod, |s1_mode, s1_sat, s1_tag};

  for (genvar i = 2; i < NUM_STAGE; i++) begin : g_mid
    if (i > 2) begin : g_fwd
      assign mid_d[i] = mid_q[i-1];
    end
    assign load[i] = vld[i-1] & rdy[i];

    hls_sobel_pipe_stage #(.W(WM), .RST_DATA(1'b0)) u_stg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (load[i]),
      .d_i        (mid_d[i]),
      .down_rdy_i (rdy[i+1]),
      .vld_o      (vld[i]),
      .q_o        (mid_q[i])
    );
  end

  // Output stage: round half up, arithmetic shift, then clamp or truncate.
  logic signed [PW-1:0]    m_prod;
  logic                    m_sgn;
  logic                    m_sat;
  logic [TAG_W-1:0]        m_tag;
  logic signed [PW:0]      rnd;
  logic signed [PW:0]      shf;
  logic signed [MAX_W-1:0] wide;
  logic [MAX_W-1:0]        clamp;
  logic                    ovf_c;
  logic [WN-1:0]           fin_d;
  logic [WN-1:0]           fin_q;

  assign {m_prod, m_sgn, m_sat, m_tag} = mid_q[NUM_STAGE-1];
  assign rnd  = (PW+1)'(m_prod) + RND;
  assign shf  = rnd >>> SHIFT;
  assign wide = MAX_W'(shf);

  always_comb begin
    ovf_c = 1'b0;
    clamp = sat_clamp(wide, m_sgn, m_sat, OUT_W, ovf_c);
    fin_d = {clamp[OUT_W-1:0], ovf_c, m_tag};
  end

  assign load[NUM_STAGE] = vld[NUM_STAGE-1] & rdy[NUM_STAGE];

  hls_sobel_pipe_stage #(.W(WN), .RST_DATA(1'b1)) u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load[NUM_STAGE]),
    .d_i        (fin_d),
    .down_rdy_i (out_ready),
    .vld_o      (vld[NUM_STAGE]),
    .q_o        (fin_q)
  );

  assign {out_p, out_ovf, out_tag} = fin_q;
  assign out_valid = vld[NUM_STAGE];
  assign busy      = |vld;

endmodule

// File: tb/tb_hls_sobel_mul_pipe.sv
// Three configurations (default, OUT_W=16, SHIFT=4) share stimulus and are
// scored against an arithmetic reference model.
module tb_hls_sobel_mul_pipe;

  typedef struct {
    logic [7:0]  a;
    logic [13:0] b;
    logic [1:0]  mode;
    logic        sat;
    logic [7:0]  tag;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n, in_valid, in_sat, out_ready;
  logic [7:0]  in_a, in_tag;
  logic [13:0] in_b;
  logic [1:0]  in_mode;

  logic        rd0, rd1, rd2, ov0, ov1, ov2, f0, f1, f2, by0, by1, by2;
  logic [21:0] p0, p2;
  logic [15:0] p1;
  logic [7:0]  t0, t1, t2;

  int    checks = 0;
  int    errors = 0;
  int    acc_cnt = 0;
  bit    seen = 0;
  beat_t q[$];

  bit          hold_pend = 0;
  logic [21:0] hold_p;
  logic [7:0]  hold_t;
  logic        hold_f;
  logic [21:0] last_p0, last_p2;
  logic [15:0] last_p1;
  logic        last_f0, last_f1;

  always #5 clk = ~clk;

  hls_sobel_mul_pipe u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rd0),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sat(in_sat), .in_tag(in_tag),
    .out_valid(ov0), .out_ready(out_ready), .out_p(p0), .out_tag(t0), .out_ovf(f0), .busy(by0));

  hls_sobel_mul_pipe #(.OUT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rd1),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sat(in_sat), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(out_ready), .out_p(p1), .out_tag(t1), .out_ovf(f1), .busy(by1));

  hls_sobel_mul_pipe #(.SHIFT(4)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rd2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sat(in_sat), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(out_ready), .out_p(p2), .out_tag(t2), .out_ovf(f2), .busy(by2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, round half up, then clamp or wrap.
  function automatic longint ref_p(input beat_t bt, input int w, input int sh, output logic ovf);
    longint av, bv, p, hi, lo;
    bit s;
    av = bt.mode[0] ? longint'($signed(bt.a)) : longint'(bt.a);
    bv = bt.mode[1] ? longint'($signed(bt.b)) : longint'(bt.b);
    p  = av * bv;
    if (sh > 0) p = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    s  = (bt.mode != 2'd0);
    hi = s ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
    lo = s ? -(longint'(1) <<< (w - 1)) : 0;
    ovf = 1'b0;
    if (bt.sat) begin
      if (p > hi) begin p = hi; ovf = 1'b1; end
      else if (p < lo) begin p = lo; ovf = 1'b1; end
    end
    return p & ((longint'(1) <<< w) - 1);
  endfunction

  // One clock: sample mid-cycle, score transfers, then advance to next negedge.
  task automatic cyc();
    beat_t  e, bt;
    longint x0, x1, x2;
    logic   e0, e1, e2;
    #1;
    chk("lock_vld", 64'({ov1, ov2}), 64'({ov0, ov0}));
    chk("lock_rdy", 64'({rd1, rd2}), 64'({rd0, rd0}));
    if (hold_pend) begin
      chk("hold_vld", 64'(ov0), 64'(1));
      chk("hold_p",   64'(p0),  64'(hold_p));
      chk("hold_tag", 64'(t0),  64'(hold_t));
      chk("hold_ovf", 64'(f0),  64'(hold_f));
    end
    if (reset_n && ov0 && out_ready) begin
      seen = 1;
      if (q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        e  = q.pop_front();
        x0 = ref_p(e, 22, 0, e0);
        x1 = ref_p(e, 16, 0, e1);
        x2 = ref_p(e, 22, 4, e2);
        chk("p0", 64'(p0), 64'(x0));  chk("ovf0", 64'(f0), 64'(e0));
        chk("p1", 64'(p1), 64'(x1));  chk("ovf1", 64'(f1), 64'(e1));
        chk("p2", 64'(p2), 64'(x2));  chk("ovf2", 64'(f2), 64'(e2));
        chk("tag", 64'({t0, t1, t2}), 64'({e.tag, e.tag, e.tag}));
        last_p0 = p0; last_p1 = p1; last_p2 = p2; last_f0 = f0; last_f1 = f1;
      end
    end
    if (reset_n && in_valid && rd0) begin
      bt.a = in_a; bt.b = in_b; bt.mode = in_mode; bt.sat = in_sat; bt.tag = in_tag;
      q.push_back(bt);
      acc_cnt++;
    end
    hold_pend = reset_n && ov0 && !out_ready;
    hold_p = p0; hold_t = t0; hold_f = f0;
    if (!reset_n) q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one_beat(input logic [7:0] a, input logic [13:0] b, input logic [1:0] m,
                          input logic s, input logic [7:0] tag);
    int lat;
    in_valid = 1; in_a = a; in_b = b; in_mode = m; in_sat = s; in_tag = tag; out_ready = 1;
    cyc();
    in_valid = 0;
    seen = 0;
    lat = 0;
    while (!seen && lat < 20) begin
      lat++;
      cyc();
    end
    chk("latency", 64'(lat), 64'(4));
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; in_sat = 0; in_tag = 0;
    out_ready = 1;
    @(negedge clk);
    cyc();
    cyc();
    #1;
    chk("rst_vld",  64'(ov0), 64'(0));
    chk("rst_busy", 64'(by0), 64'(0));
    chk("rst_rdy",  64'(rd0), 64'(1));
    chk("rst_out",  64'({p0, t0, f0}), 64'(0));
    reset_n = 1;

    one_beat(8'd255, 14'd16383, 2'd0, 1'b0, 8'd1);
    chk("uu_p", 64'(last_p0), 64'(22'h3FBF01));
    chk("uu_ovf", 64'(last_f0), 64'(0));
    one_beat(8'hFF, 14'd100, 2'd1, 1'b0, 8'd2);
    chk("su_p", 64'(last_p0), 64'(22'h3FFF9C));
    one_beat(8'd255, 14'd16383, 2'd0, 1'b1, 8'd3);
    chk("sat16_p", 64'(last_p1), 64'(16'hFFFF));
    chk("sat16_ovf", 64'(last_f1), 64'(1));
    one_beat(8'd255, 14'd16383, 2'd0, 1'b0, 8'd4);
    chk("trunc16_p", 64'(last_p1), 64'(16'hBF01));
    chk("trunc16_ovf", 64'(last_f1), 64'(0));
    one_beat(8'd3, 14'd7, 2'd0, 1'b0, 8'd5);
    chk("rnd_3x7", 64'(last_p2), 64'(1));
    one_beat(8'd5, 14'd5, 2'd0, 1'b0, 8'd6);
    chk("rnd_5x5", 64'(last_p2), 64'(2));

    // Backpressure: fill with consumer stalled, then drain at full rate.
    out_ready = 0; in_valid = 1; acc_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      in_a = 8'($urandom); in_b = 14'($urandom); in_mode = 2'($urandom);
      in_sat = 1'($urandom); in_tag = 8'(8'h10 + k);
      cyc();
    end
    #1;
    chk("bp_accepted", 64'(acc_cnt), 64'(4));
    chk("bp_in_ready", 64'(rd0), 64'(0));
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_stream", 64'(ov0), 64'(1));
      cyc();
    end
    chk("bp_drained", 64'(q.size()), 64'(0));

    // Reset with three beats in flight and a beat offered in the reset cycle.
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_a = 8'($urandom); in_b = 14'($urandom); in_tag = 8'(8'h20 + k);
      cyc();
    end
    reset_n = 0; in_tag = 8'h2F;
    cyc();
    reset_n = 1; in_valid = 0;
    #1;
    chk("mid_rst_vld",  64'(ov0), 64'(0));
    chk("mid_rst_busy", 64'(by0), 64'(0));
    chk("mid_rst_rdy",  64'(rd0), 64'(1));
    chk("mid_rst_out",  64'({p0, t0, f0}), 64'(0));
    for (int k = 0; k < 8; k++) begin
      chk("mid_rst_quiet", 64'(ov0), 64'(0));
      cyc();
    end

    // Random traffic with random consumer stalls.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_a = 8'($urandom); in_b = 14'($urandom); in_mode = 2'($urandom);
      in_sat = 1'($urandom); in_tag = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 40 && q.size() != 0; k++) cyc();
    chk("final_drain", 64'(q.size()), 64'(0));
    #1;
    chk("final_busy", 64'(by0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_sobel_mul_pipe.md
HLS_SOBEL_MUL_PIPE -- requirements
Module: hls_sobel_mul_pipe

Interface
REQ-001 SHALL have parameter A_W, default 8, operand A width.
REQ-002 SHALL have parameter B_W, default 14, operand B width.
REQ-003 SHALL have parameter OUT_W, default 22, result width.
REQ-004 SHALL have parameter NUM_STAGE, default 4, pipeline depth; legal range 3..8.
REQ-005 SHALL have parameter SHIFT, default 0, right-shift applied to the product before output; legal range 0..A_W+B_W-1.
REQ-006 SHALL have parameter TAG_W, default 8, sideband width.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1, operand beat valid.
REQ-010 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-011 SHALL have port in_a, input, A_W, operand A.
REQ-012 SHALL have port in_b, input, B_W, operand B.
REQ-013 SHALL have port in_mode, input, 2, signedness: bit0 marks A as signed and bit1 marks B as signed.
REQ-014 SHALL have port in_sat, input, 1, saturate (1) or truncate (0).
REQ-015 SHALL have port in_tag, input, TAG_W, sideband carried with the beat.
REQ-016 SHALL have port out_valid, output, 1, result valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-018 SHALL have port out_p, output, OUT_W, result.
REQ-019 SHALL have port out_tag, output, TAG_W, tag of the result.
REQ-020 SHALL have port out_ovf, output, 1, result was clamped.
REQ-021 SHALL have port busy, output, 1, OR of all stage valid bits.

Function
REQ-022 SHALL accept a beat on any rising edge where in_valid and in_ready are both 1, and SHALL transfer a result on any edge where out_valid and out_ready are both 1.
REQ-023 SHALL use stages as follows: stage 1 registers the operands, mode, sat and tag; stage 2 forms the product; stages 3..NUM_STAGE-1 are retiming registers; stage NUM_STAGE applies round, shift and saturation and drives the outputs.
REQ-024 SHALL advance stage i when it is valid and either stage i+1 is empty or stage i+1 is advancing; the output stage advances when out_ready=1 or out_valid=0; in_ready is combinational: stage 1 is empty or stage 1 is advancing.
REQ-025 SHALL collapse bubbles, so that an empty stage is filled regardless of downstream stall.
REQ-026 SHALL, with out_ready held at 1, assert out_valid exactly NUM_STAGE cycles after acceptance, and SHALL sustain a throughput of 1 beat/cycle.
REQ-027 SHALL sign-extend each operand per in_mode, or zero-extend it, to A_W+1 and B_W+1 bits, and SHALL form an exact product of A_W+B_W+2 bits.
REQ-028 SHALL, when SHIFT>0, add 2^(SHIFT-1) and then arithmetic-shift right by SHIFT (round half up); when SHIFT=0 the product passes unchanged.
REQ-029 SHALL treat the result as signed if either mode bit is 1, and as unsigned otherwise.
REQ-030 SHALL, with sat=1, clamp a value outside the OUT_W range to the signed or unsigned min/max and set out_ovf=1; with sat=0, output the low OUT_W bits and set out_ovf=0.
REQ-031 SHALL hold out_p, out_tag and out_ovf stable while out_valid=1 and out_ready=0.
REQ-032 SHALL preserve result order and SHALL never drop or duplicate a beat.
REQ-033 SHALL hold at most NUM_STAGE beats in flight; when full with out_ready=0, in_ready=0.

Reset
REQ-034 SHALL, on an edge with reset_n=0, clear all stage valid bits, so that out_valid=0, busy=0 and in_ready=1 on the following cycle.
REQ-035 SHALL, when reset_n=0, clear out_p, out_tag and out_ovf to 0; data registers other than the outputs need no reset.
REQ-036 SHALL discard in-flight beats on reset mid-operation, and SHALL ignore a beat presented in the reset cycle.

Structure
REQ-037 SHALL place the mode encoding constants (MODE_UU=0, MODE_SU=1, MODE_US=2, MODE_SS=3) and a saturation helper function in shared package hls_sobel_pkg.
REQ-038 SHALL use one sub-module, hls_sobel_pipe_stage: a parametrised-width payload register with valid bit and advance logic, instantiated per stage.

Verification
REQ-039 SHALL verify unsigned defaults: A=255, B=16383, mode=0, sat=0 -> out_p=4177665 (0x3FBF01) 4 cycles later, out_ovf=0.
REQ-040 SHALL verify signed mode: A=0xFF with mode=1, B=100 -> out_p=-100 (0x3FFF9C).
REQ-041 SHALL verify saturation with OUT_W=16, unsigned: 255*16383 with sat=1 -> out_p=65535 and out_ovf=1; with sat=0 -> out_p=0xBF01 and out_ovf=0.
REQ-042 SHALL verify rounding with SHIFT=4: 3*7 -> out_p=1; 5*5 -> out_p=2.
REQ-043 SHALL verify backpressure: continuous in_valid with out_ready=0 for 10 cycles -> exactly 4 beats accepted and in_ready=0; after release, all tags emerge in order at 1 per cycle.
REQ-044 SHALL verify reset mid-stream: reset_n=0 for 1 cycle with 3 beats in flight -> no out_valid afterwards and busy=0.
